// File: rtl/sha256_top.sv
// SHA-256 streaming hash core: 32-bit big-endian words in, 256-bit digest out; optional SHA256_DIGEST_CLEAR_EN zeroes s_data outside s_valid.
// Latency: per 512-bit block 65 cycles (64 rounds + H update); final digest one cycle after the last H update, with padding slots one per cycle.
// Backpressure: m_ready is registered, high only while loading (IDLE/LOAD); words offered while m_ready=0 are ignored.
module sha256_top (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         m_valid,
    input  logic [31:0]  m_data,
    input  logic         m_last,
    input  logic [1:0]   m_last_sz,
    output logic         m_ready,
    output logic         s_valid,
    output logic [255:0] s_data
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PAD      = 3'd2,
        ST_COMPRESS = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t       state_q;
    logic         ready_q;
    logic         s_valid_q;
    logic [255:0] digest_q;
    logic [31:0]  h_q [0:7];      // running hash value
    logic [31:0]  v_q [0:7];      // working variables a..h
    logic [31:0]  w_q [0:15];     // block buffer / schedule window, oldest word in w_q[0]
    logic [3:0]   widx_q;         // word slot of the block being filled
    logic [63:0]  bitlen_q;       // message length in bits
    logic [6:0]   rnd_q;          // 0..63 rounds, 64 = H update
    logic         last_seen_q;    // final message word has been accepted
    logic         pad80_q;        // 0x80 marker already placed
    logic         len_mode_q;     // this block carries the length in words 14-15
    logic         final_q;        // block being compressed is the last one

    logic         accept_d;
    logic [2:0]   nbytes_d;
    logic [31:0]  in_word_d;
    logic [31:0]  pad_word_d;
    logic [31:0]  w_new_d;
    logic [31:0]  t1_d;
    logic [31:0]  t2_d;
    logic [31:0]  sum_d [0:7];

    // Input word formatting, padding word selection, schedule and round arithmetic
    always_comb begin
        accept_d = m_valid && ready_q;
        nbytes_d = m_last ? ({1'b0, m_last_sz} + 3'd1) : 3'd4;
        in_word_d = m_data;
        if (m_last) begin
            case (m_last_sz)
                2'd0:    in_word_d = {m_data[31:24], 24'h800000};
                2'd1:    in_word_d = {m_data[31:16], 16'h8000};
                2'd2:    in_word_d = {m_data[31:8], 8'h80};
                default: in_word_d = m_data;
            endcase
        end

        pad_word_d = 32'h0;
        if (!pad80_q)
            pad_word_d = 32'h80000000;
        else if (widx_q == 4'd14)
            pad_word_d = bitlen_q[63:32];
        else if (widx_q == 4'd15 && len_mode_q)
            pad_word_d = bitlen_q[31:0];

        w_new_d = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
                + w_q[9]
                + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
                + w_q[0];

        t1_d = v_q[7]
             + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
             + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
             + K_TAB[rnd_q[5:0]]
             + w_q[0];
        t2_d = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
             + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));

        for (int i = 0; i < 8; i++) sum_d[i] = h_q[i] + v_q[i];
    end

    // Control FSM plus block buffer, round engine and hash state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            s_valid_q   <= 1'b0;
            digest_q    <= '0;
            widx_q      <= '0;
            bitlen_q    <= '0;
            rnd_q       <= '0;
            last_seen_q <= 1'b0;
            pad80_q     <= 1'b0;
            len_mode_q  <= 1'b0;
            final_q     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= IV[i];
                v_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            s_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    ready_q <= 1'b1;
                    if (accept_d) begin
                        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                        w_q[15]  <= in_word_d;
                        widx_q   <= widx_q + 4'd1;
                        bitlen_q <= bitlen_q + {58'd0, nbytes_d, 3'b000};
                        if (m_last) begin
                            last_seen_q <= 1'b1;
                            if (nbytes_d != 3'd4) pad80_q <= 1'b1;
                        end
                        if (widx_q == 4'd15) begin
                            state_q <= ST_COMPRESS;
                            ready_q <= 1'b0;
                            rnd_q   <= '0;
                            for (int i = 0; i < 8; i++) v_q[i] <= h_q[i];
                        end else if (m_last) begin
                            state_q <= ST_PAD;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_PAD: begin
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                    w_q[15] <= pad_word_d;
                    widx_q  <= widx_q + 4'd1;
                    if (!pad80_q) pad80_q <= 1'b1;
                    else if (widx_q == 4'd14) len_mode_q <= 1'b1;
                    if (widx_q == 4'd15) begin
                        final_q <= len_mode_q;
                        state_q <= ST_COMPRESS;
                        rnd_q   <= '0;
                        for (int i = 0; i < 8; i++) v_q[i] <= h_q[i];
                    end
                end
                ST_COMPRESS: begin
                    if (rnd_q != 7'd64) begin
                        v_q[7] <= v_q[6];
                        v_q[6] <= v_q[5];
                        v_q[5] <= v_q[4];
                        v_q[4] <= v_q[3] + t1_d;
                        v_q[3] <= v_q[2];
                        v_q[2] <= v_q[1];
                        v_q[1] <= v_q[0];
                        v_q[0] <= t1_d + t2_d;
                        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                        w_q[15] <= w_new_d;
                        rnd_q   <= rnd_q + 7'd1;
                    end else begin
                        for (int i = 0; i < 8; i++) h_q[i] <= sum_d[i];
                        if (final_q) begin
                            state_q   <= ST_DONE;
                            s_valid_q <= 1'b1;
                            digest_q  <= {sum_d[0], sum_d[1], sum_d[2], sum_d[3],
                                          sum_d[4], sum_d[5], sum_d[6], sum_d[7]};
                        end else if (last_seen_q) begin
                            state_q <= ST_PAD;
                        end else begin
                            state_q <= ST_LOAD;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Fresh start for the next message: IV, empty counters and flags
                    for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
                    widx_q      <= '0;
                    bitlen_q    <= '0;
                    rnd_q       <= '0;
                    last_seen_q <= 1'b0;
                    pad80_q     <= 1'b0;
                    len_mode_q  <= 1'b0;
                    final_q     <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_ready = ready_q;
    assign s_valid = s_valid_q;
`ifdef SHA256_DIGEST_CLEAR_EN
    assign s_data = s_valid_q ? digest_q : 256'd0;
`else
    assign s_data = digest_q;
`endif

endmodule

// File: tb/tb_sha256_top.sv
// Bench for sha256_top: directed and random messages against a byte-level SHA-256 model.
// Expected digests are queued when a message is issued; a monitor pops them on every s_valid.
// Also checks reset values, m_ready stall lengths, abort on reset and the digest-clear option.
module tb_sha256_top;

    typedef logic [7:0] bq_t[$];

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         m_valid = 1'b0;
    logic [31:0]  m_data = '0;
    logic         m_last = 1'b0;
    logic [1:0]   m_last_sz = '0;
    logic         m_ready;
    logic         s_valid;
    logic [255:0] s_data;

    int errors = 0;
    int checks = 0;
    logic [255:0] exp_q[$];
    bit   prev_vld = 1'b0;

    sha256_top dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_last_sz (m_last_sz),
        .m_ready   (m_ready),
        .s_valid   (s_valid),
        .s_data    (s_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 over a byte queue: explicit padding, 64-word expansion per block
    function automatic logic [255:0] sha_ref(input bq_t m);
        bq_t p;
        logic [63:0] bl;
        logic [31:0] h [8];
        logic [31:0] v [8];
        logic [31:0] w [64];
        logic [31:0] t1, t2;
        p  = m;
        bl = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        h = IV;
        for (int blk = 0; blk < p.size() / 64; blk++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {p[blk*64+4*t], p[blk*64+4*t+1], p[blk*64+4*t+2], p[blk*64+4*t+3]};
            for (int t = 16; t < 64; t++)
                w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            v = h;
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
                t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
                v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every digest pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n) begin
            if (s_valid) begin
                if (prev_vld) chk("s_valid_single_pulse", 256'd1, 256'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_digest", s_data, 256'd0);
                    if (s_data == 256'd0) begin
                        errors++;
                        $display("FAIL unexpected_digest got=zero_digest required=no_pulse");
                    end
                end else begin
                    chk("digest", s_data, exp_q.pop_front());
                end
            end
`ifdef SHA256_DIGEST_CLEAR_EN
            else chk("s_data_cleared", s_data, 256'd0);
`endif
        end
        prev_vld = s_valid && reset_n;
    end

    // Offer one word and hold it until accepted; returns number of stalled cycles
    task automatic xfer(input logic [31:0] d, input logic l, input logic [1:0] sz, output int n);
        n = 0;
        m_valid = 1'b1; m_data = d; m_last = l; m_last_sz = sz;
        while (!m_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            errors++; checks++;
            $display("FAIL xfer_timeout got=no_ready required=ready");
        end
        @(posedge clk); #1;
        m_valid = 1'b0; m_data = $urandom; m_last = 1'($urandom); m_last_sz = 2'($urandom);
    endtask

    task automatic send_msg(input bq_t m, input int gapmax, output int stalls);
        int nw, nb, n;
        logic [31:0] w;
        nw = (m.size() + 3) / 4;
        stalls = 0;
        for (int i = 0; i < nw; i++) begin
            nb = (i == nw - 1) ? m.size() - 4*i : 4;
            w = '0;
            for (int b = 0; b < 4; b++) w = {w[23:0], (b < nb) ? m[4*i+b] : 8'($urandom)};
            if (gapmax > 0) begin
                repeat ($urandom_range(gapmax, 0)) @(posedge clk);
                #1;
            end
            xfer(w, i == nw - 1, 2'(nb - 1), n);
            stalls += n;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            errors++; checks++;
            $display("FAIL drain_timeout got=%0d_pending required=0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic count_ready_low(output int cnt);
        cnt = 0;
        forever begin
            @(negedge clk);
            if (m_ready || cnt >= 500) break;
            cnt++;
        end
    endtask

    initial begin
        bq_t m;
        int  st, cnt;
        int  lens [14] = '{1, 3, 4, 52, 55, 56, 57, 60, 63, 64, 65, 119, 120, 128};

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_m_ready", 256'(m_ready), 256'd0);
        chk("reset_s_valid", 256'(s_valid), 256'd0);
        chk("reset_s_data", s_data, 256'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 256'(m_ready), 256'd1);

        // "abc" single word
        m = str2q("abc");
        exp_q.push_back(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        send_msg(m, 0, st);
        drain();

        // Three words back-to-back: no stall, one compression (13 pad slots + 65 + DONE)
        m = str2q("abcdefghjklm");
        exp_q.push_back(sha_ref(m));
        send_msg(m, 0, st);
        chk("three_words_no_stall", 256'(st), 256'd0);
        count_ready_low(cnt);
        chk("one_compression_ready_low", 256'(cnt), 256'd79);
        drain();

        // 56-byte message needing an extra padding block
        m = str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        exp_q.push_back(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
        send_msg(m, 0, st);
        drain();

        // Full first block: ready low for 65 cycles, junk offered meanwhile is ignored
        m = {};
        for (int i = 0; i < 68; i++) m.push_back(8'($urandom));
        exp_q.push_back(sha_ref(m));
        for (int i = 0; i < 16; i++) xfer({m[4*i], m[4*i+1], m[4*i+2], m[4*i+3]}, 1'b0, 2'd3, st);
        m_valid = 1'b1; m_data = $urandom; m_last = 1'b1; m_last_sz = 2'd0;
        count_ready_low(cnt);
        chk("block_stall_cycles", 256'(cnt), 256'd65);
        xfer({m[64], m[65], m[66], m[67]}, 1'b1, 2'd3, st);
        drain();

        // Reset during compression aborts the message
        m = str2q("abcdefghjk");
        send_msg(m, 0, st);
        repeat (30) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("abort_m_ready", 256'(m_ready), 256'd0);
        chk("abort_s_valid", 256'(s_valid), 256'd0);
        chk("abort_s_data", s_data, 256'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        m = str2q("abc");
        exp_q.push_back(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        send_msg(m, 0, st);
        drain();

        // Two "abc" messages back-to-back
        m = str2q("abc");
        exp_q.push_back(sha_ref(m));
        exp_q.push_back(sha_ref(m));
        send_msg(m, 0, st);
        send_msg(m, 0, st);
        drain();

        // Padding boundary lengths and random messages with random gaps
        for (int k = 0; k < 22; k++) begin
            m = {};
            cnt = (k < 14) ? lens[k] : $urandom_range(140, 1);
            for (int i = 0; i < cnt; i++) m.push_back(8'($urandom));
            exp_q.push_back(sha_ref(m));
            send_msg(m, (k % 2) ? 2 : 0, st);
            if (k % 3 == 0) drain();
        end
        drain();

        chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_top.md
SHA256_TOP -- requirements
Module: sha256_top

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset; clears all state immediately.
REQ-003 m_valid  input  1  input word valid.
REQ-004 m_data  input  32  message word, big-endian: byte 0 in [31:24].
REQ-005 m_last  input  1  current word is the final word of the message.
REQ-006 m_last_sz  input  2  with m_last, valid bytes minus one (00=1 byte in [31:24] … 11=4 bytes); ignored when m_last=0.
REQ-007 m_ready  output  1  core can accept a word this cycle.
REQ-008 s_valid  output  1  one-cycle pulse: s_data holds a finished digest.
REQ-009 s_data  output  256  digest H0..H7, H0 in [255:224].

Function
REQ-010 Transfer: a word is accepted on a rising edge where m_valid=1 and m_ready=1. Input is ignored when m_ready=0.
REQ-011 Non-last accepted words are full 4-byte words. The last word contributes m_last_sz+1 bytes. Unused low bytes are discarded.
REQ-012 States: IDLE, LOAD, PAD, COMPRESS, DONE.
  - IDLE -> LOAD on the first accepted word.
  - LOAD -> COMPRESS after 16 words fill a block.
  - LOAD -> PAD on the m_last word.
REQ-013 m_ready=1 only in IDLE and LOAD.
REQ-014 Byte/bit counter: 64-bit message bit length, incremented per accepted byte; wraps modulo 2^64.
REQ-015 PAD, one word slot per cycle, FIPS 180-4 padding:
  - 0x80 byte directly after the last valid byte (in the same word when it holds fewer than 4 bytes, else the next word).
  - zero fill.
  - 64-bit bit length in words 14-15 of the final block.
REQ-016 If the 0x80 byte lands in word 14 or 15, zero-fill and compress that block, then build a second block (zeros + length).
REQ-017 COMPRESS: message schedule in a 16-word sliding window; exactly one SHA-256 round per cycle; 64 round cycles, then 1 cycle adding the working variables into H0..H7.
REQ-018 After the H update, return to LOAD for a non-final block, or go to DONE for the final block.
REQ-019 DONE: lasts one cycle.
  - s_valid=1 and s_data=final H.
  - H reinitialised to the FIPS IV (6a09e667 … 5be0cd19).
  - Counters cleared; next state IDLE.
REQ-020 Back-to-back messages: accepted starting the cycle after DONE, with no state carried over.
REQ-021 All arithmetic is modulo 2^32. Round constants K0..K63 per FIPS 180-4.

Reset
REQ-022 Reset values:
  - m_ready=0, s_valid=0, s_data=0.
  - H=IV, counters=0, state=IDLE.
  - m_ready rises in the first cycle after reset_n deasserts.
REQ-023 reset_n asserted mid-message or mid-compression aborts the message; no s_valid is produced for it.

Configuration
REQ-024 Macro SHA256_DIGEST_CLEAR_EN.
  - Defined: s_data=0 whenever s_valid=0.
  - Undefined: s_data holds the last digest until the next DONE or reset.

Verification
REQ-025 Stimulus "abc": one word 0x61626300, m_last=1, m_last_sz=10.
  - s_data=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  - Single s_valid pulse.
REQ-026 Stimulus "abcd","efgh","jklm" on consecutive cycles, m_last on the third, m_last_sz=11.
  - All three accepted without stall.
  - One compression.
  - s_data equals a software SHA-256 of "abcdefghjklm".
REQ-027 Stimulus: 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (14 words, last m_last_sz=11).
  - Extra padding block produced.
  - s_data=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-028 Stimulus: 64-byte message (16 words, no m_last on word 16, then ...).
  - m_ready low for exactly 65 cycles after word 16.
  - Words presented while m_ready=0 are not consumed.
REQ-029 Stimulus: reset_n pulsed low during COMPRESS of a message, then "abc" sent.
  - No s_valid from the aborted message.
  - "abc" digest correct.
REQ-030 Stimulus: two "abc" messages back-to-back.
  - Two identical digests.
  - With SHA256_DIGEST_CLEAR_EN defined, s_data=0 between the s_valid pulses.
